spi_reg_arbiter: RTL and testbench

SPI_REG_ARBITER -- requirements
Module: spi_reg_arbiter

---
 rtl/spi_reg_arbiter_pkg.sv | 32 +++
 rtl/spi_reg_arbiter_rr_arb2.sv | 43 ++++
 rtl/spi_reg_arbiter.sv | 177 +++++++++++++++++
 tb/tb_spi_reg_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_arbiter_pkg.sv
// Shared types and constants for the SPI register-access arbiter.
// Holds the FSM encoding, bus widths and the small byte-building helpers.
package spi_reg_arbiter_pkg;

  localparam int NUM_REQ         = 2;
  localparam int BYTE_W          = 8;
  localparam int ADDR_W          = 7;
  localparam int RD_FLAG_BIT_DEF = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_RX = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  // The read flag overlays one bit of the zero-extended register address.
  function automatic logic [BYTE_W-1:0] mk_addr_byte(input logic rnw,
                                                     input logic [ADDR_W-1:0] addr,
                                                     input int flag_bit);
    logic [BYTE_W-1:0] b;
    b = {1'b0, addr};
    b[flag_bit[2:0]] = rnw;
    return b;
  endfunction

  function automatic logic [NUM_REQ-1:0] idx_onehot(input logic idx);
    return {idx, ~idx};
  endfunction

endpackage

// File: rtl/spi_reg_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves
// to the requester that did not win whenever the parent accepts a grant.
module spi_rr_arb2
  import spi_reg_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection: pointer names the requester with priority.
  always_comb begin
    gnt_o = 2'b00;
    if (ptr_q == 1'b0) begin
      if (req_i[0])      gnt_o = 2'b01;
      else if (req_i[1]) gnt_o = 2'b10;
      else               gnt_o = 2'b00;
    end else begin
      if (req_i[1])      gnt_o = 2'b10;
      else if (req_i[0]) gnt_o = 2'b01;
      else               gnt_o = 2'b00;
    end
  end

  // Pointer next state.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (gnt_o != 2'b00)) ptr_d = ~gnt_o[1];
    else                               ptr_d = ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/spi_reg_arbiter.sv
// Arbitrates two register-access requesters onto one SPI master, presenting
// the address/data bytes as a show-ahead FIFO and returning the second rx byte.
module spi_reg_arbiter
  import spi_reg_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int RD_FLAG_BIT = RD_FLAG_BIT_DEF
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_rnw_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*BYTE_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [BYTE_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      tx_empty_o,
  output logic [BYTE_W-1:0]         tx_data_o,
  input  logic                      tx_rdreq_i,
  input  logic [BYTE_W-1:0]         rx_data_i,
  input  logic                      rx_wrreq_i,
  input  logic                      spi_ready_i
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  state_e              state_q, state_d;
  logic                idx_q, idx_d, rnw_q, rnw_d, tx_sel_q, tx_sel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   wdata_q, wdata_d, data_byte_q, data_byte_d, rd_byte_q, rd_byte_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d, rsp_rdata_q, rsp_rdata_d;
  logic                tx_empty_q, tx_empty_d, rsp_err_q, rsp_err_d;
  logic [1:0]          rx_cnt_q, rx_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]  gnt_s;
  logic                grant_s, win_idx_s, rx_hit_s, rx_last_s, to_hit_s;

  assign grant_s   = (state_q == ST_IDLE) && spi_ready_i && (req_valid_i != 2'b00);
  assign win_idx_s = gnt_s[1];
  assign rx_hit_s  = rx_wrreq_i && ((state_q == ST_SEND) || (state_q == ST_WAIT_RX));
  assign rx_last_s = rx_hit_s && (rx_cnt_q == 2'd1);
  assign to_hit_s  = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  spi_rr_arb2 u_arb (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_i     (req_valid_i),
    .advance_i (grant_s),
    .gnt_o     (gnt_s)
  );

  // Transaction FSM and datapath next state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_byte_d = data_byte_q;
    tx_sel_d    = tx_sel_q;
    tx_data_d   = tx_data_q;
    tx_empty_d  = tx_empty_q;
    to_cnt_d    = to_cnt_q;
    req_ready_d = 2'b00;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = 8'h00;
    rsp_err_d   = 1'b0;
    rx_cnt_d    = (rx_hit_s && (rx_cnt_q != 2'd2)) ? rx_cnt_q + 2'd1 : rx_cnt_q;
    rd_byte_d   = rx_last_s ? rx_data_i : rd_byte_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d     = ST_LOAD;
          req_ready_d = gnt_s;
          idx_d       = win_idx_s;
          rnw_d       = req_rnw_i[win_idx_s];
          addr_d      = req_addr_i[win_idx_s*ADDR_W +: ADDR_W];
          wdata_d     = req_wdata_i[win_idx_s*BYTE_W +: BYTE_W];
          to_cnt_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        tx_data_d   = mk_addr_byte(rnw_q, addr_q, RD_FLAG_BIT);
        data_byte_d = rnw_q ? 8'h00 : wdata_q;
        tx_empty_d  = 1'b0;
        tx_sel_d    = 1'b0;
        rx_cnt_d    = 2'd0;
        rd_byte_d   = 8'h00;
        to_cnt_d    = to_cnt_q + TO_W'(1);
        state_d     = ST_SEND;
      end
      ST_SEND, ST_WAIT_RX: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if ((state_q == ST_SEND) && tx_rdreq_i && !tx_empty_q) begin
          if (!tx_sel_q) begin
            tx_sel_d  = 1'b1;
            tx_data_d = data_byte_q;
          end else begin
            tx_empty_d = 1'b1;
            state_d    = ST_WAIT_RX;
          end
        end
        // A finished exchange wins over a timeout landing on the same cycle.
        if ((state_q == ST_WAIT_RX) && ((rx_cnt_q == 2'd2) || rx_last_s)) begin
          state_d     = ST_RESP;
          rsp_valid_d = idx_onehot(idx_q);
          rsp_rdata_d = rnw_q ? (rx_last_s ? rx_data_i : rd_byte_q) : 8'h00;
        end else if (to_hit_s) begin
          state_d     = ST_RESP;
          tx_empty_d  = 1'b1;
          rsp_valid_d = idx_onehot(idx_q);
          rsp_err_d   = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        tx_empty_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= 7'h00;
      wdata_q     <= 8'h00;
      data_byte_q <= 8'h00;
      tx_sel_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_empty_q  <= 1'b1;
      rx_cnt_q    <= 2'd0;
      rd_byte_q   <= 8'h00;
      to_cnt_q    <= '0;
      req_ready_q <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_byte_q <= data_byte_d;
      tx_sel_q    <= tx_sel_d;
      tx_data_q   <= tx_data_d;
      tx_empty_q  <= tx_empty_d;
      rx_cnt_q    <= rx_cnt_d;
      rd_byte_q   <= rd_byte_d;
      to_cnt_q    <= to_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign tx_empty_o  = tx_empty_q;
  assign tx_data_o   = tx_data_q;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Directed bench: a small SPI-master model drives the FIFO side, expected
// responses go into a queue that an independent monitor drains.
module tb_spi_reg_arbiter;
  import spi_reg_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [1:0]  req_valid_i = 2'b00, req_rnw_i = 2'b00;
  logic [13:0] req_addr_i = 14'h0;
  logic [15:0] req_wdata_i = 16'h0;
  logic [1:0]  req_ready_o, rsp_valid_o;
  logic [7:0]  rsp_rdata_o, tx_data_o;
  logic        rsp_err_o, tx_empty_o;
  logic        tx_rdreq_i = 1'b0, rx_wrreq_i = 1'b0, spi_ready_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;

  spi_reg_arbiter #(.TIMEOUT_CYC(64), .RD_FLAG_BIT(7)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid_i(req_valid_i), .req_rnw_i(req_rnw_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .tx_empty_o(tx_empty_o), .tx_data_o(tx_data_o),
    .tx_rdreq_i(tx_rdreq_i), .rx_data_i(rx_data_i),
    .rx_wrreq_i(rx_wrreq_i), .spi_ready_i(spi_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] vld; logic [7:0] rdata; logic err; } rsp_t;
  rsp_t sb_q[$];
  int   total = 0, bad = 0, cyc = 0, rsp_cnt = 0, rsp_cyc = 0, grant_cyc = 0;
  logic tx_empty_at_rsp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rsp_valid_o !== 2'b00) begin
      rsp_t exp_r;
      rsp_cnt++;
      rsp_cyc = cyc;
      tx_empty_at_rsp = tx_empty_o;
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", {21'h0, rsp_valid_o, rsp_rdata_o, rsp_err_o}, 32'h0);
      end else begin
        exp_r = sb_q.pop_front();
        check("rsp", {21'h0, rsp_valid_o, rsp_rdata_o, rsp_err_o}, {21'h0, exp_r});
      end
    end
  end

  task automatic set_req(input int idx, input logic rnw, input logic [6:0] addr, input logic [7:0] wd);
    req_rnw_i[idx] = rnw;
    req_addr_i[idx*7 +: 7] = addr;
    req_wdata_i[idx*8 +: 8] = wd;
    req_valid_i[idx] = 1'b1;
  endtask

  task automatic wait_grant(input int idx);
    int n = 0;
    @(negedge clk);
    while (req_ready_o == 2'b00 && n < 50) begin @(negedge clk); n++; end
    grant_cyc = cyc;
    check("grant", {30'h0, req_ready_o}, (idx == 0) ? 32'h1 : 32'h2);
  endtask

  // mode 0: rx alongside pops, 1: rx after both pops, 2: slave silent.
  task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] r0, input logic [7:0] r1, input int mode);
    int n = 0;
    while (tx_empty_o && n < 50) begin @(negedge clk); n++; end
    check("tx_byte0", {24'h0, tx_data_o}, {24'h0, b0});
    if (mode == 2) return;
    tx_rdreq_i = 1'b1;
    if (mode == 0) begin rx_wrreq_i = 1'b1; rx_data_i = r0; end
    @(negedge clk);
    check("tx_byte1", {24'h0, tx_data_o}, {24'h0, b1});
    check("tx_nonempty_mid", {31'h0, tx_empty_o}, 32'h0);
    if (mode == 0) rx_data_i = r1;
    @(negedge clk);
    tx_rdreq_i = 1'b0;
    rx_wrreq_i = 1'b0;
    check("tx_empty_end", {31'h0, tx_empty_o}, 32'h1);
    if (mode == 1) begin
      @(negedge clk);
      rx_wrreq_i = 1'b1; rx_data_i = r0;
      @(negedge clk);
      rx_data_i = r1;
      @(negedge clk);
      rx_wrreq_i = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int prev);
    int n = 0;
    while (rsp_cnt == prev && n < 100) begin @(posedge clk); n++; end
    check("rsp_seen", rsp_cnt, prev + 1);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_empty"}, {31'h0, tx_empty_o}, 32'h1);
    check({tag, "_tx_data"}, {24'h0, tx_data_o}, 32'h0);
    check({tag, "_ready_rsp"}, {20'h0, req_ready_o, rsp_valid_o, rsp_rdata_o}, 32'h0);
    check({tag, "_err"}, {31'h0, rsp_err_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    n_rst = 1'b1;
    @(negedge clk);

    // Req0 write 0x12 <- 0xA5.
    prev = rsp_cnt;
    set_req(0, 1'b0, 7'h12, 8'hA5);
    sb_q.push_back({2'b01, 8'h00, 1'b0});
    wait_grant(0);
    req_valid_i[0] = 1'b0;
    spi_frame(8'h12, 8'hA5, 8'h00, 8'h00, 0);
    wait_rsp(prev);

    // Req1 read 0x05, slave answers 0xFF,0x3C; then a stray rx strobe in RESP.
    prev = rsp_cnt;
    set_req(1, 1'b1, 7'h05, 8'h00);
    sb_q.push_back({2'b10, 8'h3C, 1'b0});
    wait_grant(1);
    req_valid_i[1] = 1'b0;
    spi_frame(8'h85, 8'h00, 8'hFF, 8'h3C, 0);
    @(negedge clk);
    rx_wrreq_i = 1'b1; rx_data_i = 8'h77;
    @(negedge clk);
    rx_wrreq_i = 1'b0;
    check("resp_rx_ignored", {31'h0, tx_empty_o}, 32'h1);
    wait_rsp(prev);

    // Stray pops and rx strobes while idle.
    tx_rdreq_i = 1'b1; rx_wrreq_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_stray", {29'h0, tx_empty_o, req_ready_o}, 32'h4);
    end
    tx_rdreq_i = 1'b0; rx_wrreq_i = 1'b0;

    // Req1 read 0x7F, rx arrives after both pops.
    prev = rsp_cnt;
    set_req(1, 1'b1, 7'h7F, 8'h00);
    sb_q.push_back({2'b10, 8'hC3, 1'b0});
    wait_grant(1);
    req_valid_i[1] = 1'b0;
    spi_frame(8'hFF, 8'h00, 8'h11, 8'hC3, 1);
    wait_rsp(prev);

    // SPI busy gates arbitration; req0 withdraws before being granted.
    spi_ready_i = 1'b0;
    set_req(0, 1'b0, 7'h2B, 8'h66);
    set_req(1, 1'b0, 7'h40, 8'h5A);
    @(negedge clk);
    req_valid_i[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_no_grant", {30'h0, req_ready_o}, 32'h0);
    end
    prev = rsp_cnt;
    sb_q.push_back({2'b10, 8'h00, 1'b0});
    spi_ready_i = 1'b1;
    wait_grant(1);
    req_valid_i[1] = 1'b0;
    spi_frame(8'h40, 8'h5A, 8'hEE, 8'hDD, 0);
    wait_rsp(prev);

    // Silent slave: timeout 64 cycles after the LOAD cycle.
    prev = rsp_cnt;
    set_req(0, 1'b0, 7'h33, 8'h99);
    sb_q.push_back({2'b01, 8'h00, 1'b1});
    wait_grant(0);
    req_valid_i[0] = 1'b0;
    spi_frame(8'h33, 8'h00, 8'h00, 8'h00, 2);
    wait_rsp(prev);
    check("timeout_latency", rsp_cyc - grant_cyc, 32'd64);
    check("timeout_tx_empty", {31'h0, tx_empty_at_rsp}, 32'h1);

    // Reset after the first pop drops the transaction silently.
    prev = rsp_cnt;
    set_req(1, 1'b0, 7'h01, 8'h02);
    wait_grant(1);
    req_valid_i[1] = 1'b0;
    while (tx_empty_o) @(negedge clk);
    tx_rdreq_i = 1'b1;
    @(negedge clk);
    tx_rdreq_i = 1'b0;
    check("pre_reset_byte1", {24'h0, tx_data_o}, 32'h02);
    n_rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (6) @(negedge clk);
    check("no_rsp_after_reset", rsp_cnt, prev);

    // Both requesters held: grants alternate 0,1,0,1 from a fresh pointer.
    set_req(0, 1'b0, 7'h0A, 8'h55);
    set_req(1, 1'b1, 7'h21, 8'h00);
    for (int i = 0; i < 4; i++) begin
      prev = rsp_cnt;
      if (i % 2 == 0) sb_q.push_back({2'b01, 8'h00, 1'b0});
      else            sb_q.push_back({2'b10, 8'h6B, 1'b0});
      wait_grant(i % 2);
      if (i == 3) req_valid_i = 2'b00;
      if (i % 2 == 0) spi_frame(8'h0A, 8'h55, 8'h00, 8'h6B, 0);
      else            spi_frame(8'hA1, 8'h00, 8'h00, 8'h6B, 0);
      wait_rsp(prev);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
